// File: rtl/vx_vec_lane_sequencer_pkg.sv
// Shared types and widths for the vector lane sequencer slice.
//  - data_t     : one full-warp dispatch packet (scalar fields + per-thread operands)
//  - op_args_t  : operation argument bundle carried with each packet
//  - seq_state_e: sequencer FSM states
//  - log2up     : index width helper that never returns less than 1
package vx_vec_lane_sequencer_pkg;

    localparam int NUM_THREADS   = 4;
    localparam int XLEN          = 32;
    localparam int UUID_WIDTH    = 16;
    localparam int ISSUE_WIS_W   = 2;
    localparam int PC_BITS       = 32;
    localparam int INST_ALU_BITS = 4;
    localparam int NR_BITS       = 6;
    localparam int NT_WIDTH      = 2;

    typedef struct packed {
        logic       use_imm;
        logic       is_w;
        logic [5:0] imm_sel;
    } op_args_t;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]                uuid;
        logic [ISSUE_WIS_W-1:0]               wis;
        logic [NUM_THREADS-1:0]               tmask;
        logic [PC_BITS-1:0]                   PC;
        logic [INST_ALU_BITS-1:0]             op_type;
        op_args_t                             op_args;
        logic                                 wb;
        logic [NR_BITS-1:0]                   rd;
        logic [NT_WIDTH-1:0]                  tid;
        logic [NUM_THREADS-1:0][XLEN-1:0]     rs1_data;
        logic [NUM_THREADS-1:0][XLEN-1:0]     rs2_data;
        logic [NUM_THREADS-1:0][XLEN-1:0]     rs3_data;
    } data_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } seq_state_e;

    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_dispatch_v_if.sv
// Dispatch stream interface: valid/data/ready handshake carrying one data_t packet.
//  master: drives valid, data; receives ready
//  slave : receives valid, data; drives ready
interface vx_dispatch_v_if;
    logic                           valid;
    vx_vec_lane_sequencer_pkg::data_t data;
    logic                           ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/vx_vec_lane_sequencer_block_sel.sv
// Combinational block selector. Each block is a NUM_LANES-wide slice of the thread mask;
// a block is "live" when any bit of its slice is set.
//  in_tmask  : mask of the packet being accepted -> first_pid (lowest live block, 0 if none)
//  cur_tmask : mask of the held packet
//  cur_pid   : block currently being emitted     -> next_pid / has_next (lowest live block above cur_pid)
module vx_vec_lane_sequencer_block_sel
    import vx_vec_lane_sequencer_pkg::*;
#(
    parameter  int NUM_LANES   = 2,
    localparam int BLOCK_COUNT = NUM_THREADS / NUM_LANES,
    localparam int PID_W       = log2up(BLOCK_COUNT)
) (
    input  logic [NUM_THREADS-1:0] in_tmask,
    input  logic [NUM_THREADS-1:0] cur_tmask,
    input  logic [PID_W-1:0]       cur_pid,
    output logic [PID_W-1:0]       first_pid,
    output logic [PID_W-1:0]       next_pid,
    output logic                   has_next
);

    logic [BLOCK_COUNT-1:0] in_live;
    logic [BLOCK_COUNT-1:0] cur_live;

    // NOTE: combinational blocks use blocking '=' with a default first, so every path
    // assigns every output and no latch is inferred.
    always_comb begin
        in_live   = '0;
        cur_live  = '0;
        first_pid = '0;
        next_pid  = '0;
        has_next  = 1'b0;
        for (int b = 0; b < BLOCK_COUNT; b++) begin
            in_live[b]  = |in_tmask[b*NUM_LANES +: NUM_LANES];
            cur_live[b] = |cur_tmask[b*NUM_LANES +: NUM_LANES];
        end
        // Walk downward so the lowest matching block is the last one written.
        for (int b = BLOCK_COUNT - 1; b >= 0; b--) begin
            if (in_live[b]) begin
                first_pid = PID_W'(b);
            end
            if (cur_live[b] && (b > int'(cur_pid))) begin
                next_pid = PID_W'(b);
                has_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_vec_lane_sequencer.sv
// Vector lane sequencer: latches one full-warp dispatch packet and replays it as
// NUM_LANES-wide beats, skipping blocks whose tmask slice is empty. sop/eop frame the packet.
//  clk, reset_n      : clock, asynchronous active-low reset
//  dispatch_if       : slave side of the dispatch stream
//  out_valid/ready   : beat handshake toward the execute lanes
//  out_uuid..out_tid : packet scalar fields, constant across all beats of a packet
//  out_tmask         : tmask slice of the current beat
//  out_pid           : current block index; out_sop/out_eop first/last beat flags
//  out_rs1/2/3       : operand slices, lane i = thread pid*NUM_LANES+i
module vx_vec_lane_sequencer
    import vx_vec_lane_sequencer_pkg::*;
#(
    parameter  int NUM_LANES   = 2,
    localparam int BLOCK_COUNT = NUM_THREADS / NUM_LANES,
    localparam int PID_W       = log2up(BLOCK_COUNT)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    vx_dispatch_v_if.slave                dispatch_if,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [UUID_WIDTH-1:0]         out_uuid,
    output logic [ISSUE_WIS_W-1:0]        out_wis,
    output logic [NUM_LANES-1:0]          out_tmask,
    output logic [PC_BITS-1:0]            out_PC,
    output logic [INST_ALU_BITS-1:0]      out_op_type,
    output logic [$bits(op_args_t)-1:0]   out_op_args,
    output logic                          out_wb,
    output logic [NR_BITS-1:0]            out_rd,
    output logic [NT_WIDTH-1:0]           out_tid,
    output logic [PID_W-1:0]              out_pid,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [NUM_LANES*XLEN-1:0]     out_rs1,
    output logic [NUM_LANES*XLEN-1:0]     out_rs2,
    output logic [NUM_LANES*XLEN-1:0]     out_rs3
);

    seq_state_e       state_q, state_d;
    data_t            pkt_q;
    logic [PID_W-1:0] pid_q;
    logic             sop_q;
    logic [PID_W-1:0] first_pid, next_pid;
    logic             has_next;
    logic             accept, beat_fire, beat_last;

    vx_vec_lane_sequencer_block_sel #(
        .NUM_LANES (NUM_LANES)
    ) u_block_sel (
        .in_tmask  (dispatch_if.data.tmask),
        .cur_tmask (pkt_q.tmask),
        .cur_pid   (pid_q),
        .first_pid (first_pid),
        .next_pid  (next_pid),
        .has_next  (has_next)
    );

    // A new packet is taken when idle, or on the final beat's handshake so that
    // consecutive packets stream without a bubble.
    assign beat_fire         = out_valid && out_ready;
    assign beat_last         = out_valid && !has_next;
    assign dispatch_if.ready = (state_q == ST_IDLE) || (beat_fire && beat_last);
    assign accept            = dispatch_if.valid && dispatch_if.ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (beat_fire && beat_last) state_d = accept ? ST_ISSUE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat sequencing: pid jumps straight to the next live block; sop only on the first beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pid_q <= '0;
            sop_q <= 1'b0;
        end else if (accept) begin
            pid_q <= first_pid;
            sop_q <= 1'b1;
        end else if (beat_fire) begin
            pid_q <= beat_last ? '0 : next_pid;
            sop_q <= 1'b0;
        end
    end

    // NOTE: the packet payload has no reset; out_valid qualifies it, and leaving the wide
    // datapath out of the reset tree keeps it as plain enable flops.
    always_ff @(posedge clk) begin
        if (accept) begin
            pkt_q <= dispatch_if.data;
        end
    end

    // Output logic
    always_comb begin
        out_valid   = (state_q == ST_ISSUE);
        out_sop     = sop_q;
        out_eop     = beat_last;
        out_pid     = pid_q;
        out_uuid    = pkt_q.uuid;
        out_wis     = pkt_q.wis;
        out_PC      = pkt_q.PC;
        out_op_type = pkt_q.op_type;
        out_op_args = pkt_q.op_args;
        out_wb      = pkt_q.wb;
        out_rd      = pkt_q.rd;
        out_tid     = pkt_q.tid;
        out_tmask   = pkt_q.tmask[int'(pid_q)*NUM_LANES +: NUM_LANES];
        out_rs1     = pkt_q.rs1_data[int'(pid_q)*NUM_LANES +: NUM_LANES];
        out_rs2     = pkt_q.rs2_data[int'(pid_q)*NUM_LANES +: NUM_LANES];
        out_rs3     = pkt_q.rs3_data[int'(pid_q)*NUM_LANES +: NUM_LANES];
    end

endmodule

// File: tb/tb_vx_vec_lane_sequencer.sv
// Directed bench for vx_vec_lane_sequencer with NUM_THREADS=4, NUM_LANES=2.
module tb_vx_vec_lane_sequencer;
    import vx_vec_lane_sequencer_pkg::*;

    localparam int NUM_LANES = 2;
    localparam int PID_W     = 1;

    logic                        clk;
    logic                        reset_n;
    logic                        out_valid;
    logic                        out_ready;
    logic [UUID_WIDTH-1:0]       out_uuid;
    logic [ISSUE_WIS_W-1:0]      out_wis;
    logic [NUM_LANES-1:0]        out_tmask;
    logic [PC_BITS-1:0]          out_PC;
    logic [INST_ALU_BITS-1:0]    out_op_type;
    logic [$bits(op_args_t)-1:0] out_op_args;
    logic                        out_wb;
    logic [NR_BITS-1:0]          out_rd;
    logic [NT_WIDTH-1:0]         out_tid;
    logic [PID_W-1:0]            out_pid;
    logic                        out_sop;
    logic                        out_eop;
    logic [NUM_LANES*XLEN-1:0]   out_rs1;
    logic [NUM_LANES*XLEN-1:0]   out_rs2;
    logic [NUM_LANES*XLEN-1:0]   out_rs3;

    vx_dispatch_v_if dif ();

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    vx_vec_lane_sequencer #(
        .NUM_LANES (NUM_LANES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .dispatch_if (dif),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_uuid    (out_uuid),
        .out_wis     (out_wis),
        .out_tmask   (out_tmask),
        .out_PC      (out_PC),
        .out_op_type (out_op_type),
        .out_op_args (out_op_args),
        .out_wb      (out_wb),
        .out_rd      (out_rd),
        .out_tid     (out_tid),
        .out_pid     (out_pid),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rs3     (out_rs3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packet builder: rsN of thread t = base + N-offset + t.
    function automatic data_t mk(input logic [3:0] tm, input logic [15:0] uuid, input logic [31:0] base);
        data_t p;
        p         = '0;
        p.uuid    = uuid;
        p.wis     = 2'd2;
        p.tmask   = tm;
        p.PC      = 32'h8000_0000 + base;
        p.op_type = 4'h5;
        p.op_args = 8'h3C;
        p.wb      = 1'b1;
        p.rd      = 6'd5;
        p.tid     = 2'd1;
        for (int t = 0; t < NUM_THREADS; t++) begin
            p.rs1_data[t] = base + 32'(t);
            p.rs2_data[t] = base + 32'h100 + 32'(t);
            p.rs3_data[t] = base + 32'h200 + 32'(t);
        end
        return p;
    endfunction

    initial begin
        data_t p;
        reset_n   = 1'b0;
        out_ready = 1'b1;
        dif.valid = 1'b0;
        dif.data  = '0;
        repeat (3) tick();

        // Reset state
        check("rst_valid", out_valid, 1'b0);
        check("rst_pid",   out_pid,   1'b0);
        check("rst_sop",   out_sop,   1'b0);
        check("rst_eop",   out_eop,   1'b0);
        check("rst_ready", dif.ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Full mask: two beats
        dif.data  = mk(4'b1111, 16'h0011, 32'hA000);
        dif.valid = 1'b1;
        check("t1_ready_idle", dif.ready, 1'b1);
        tick();
        dif.valid = 1'b0;
        check("t1_b0_valid", out_valid, 1'b1);
        check("t1_b0_pid",   out_pid,   1'b0);
        check("t1_b0_tmask", out_tmask, 2'b11);
        check("t1_b0_rs1",   out_rs1,   {32'hA001, 32'hA000});
        check("t1_b0_rs2",   out_rs2,   {32'hA101, 32'hA100});
        check("t1_b0_rs3",   out_rs3,   {32'hA201, 32'hA200});
        check("t1_b0_sop",   out_sop,   1'b1);
        check("t1_b0_eop",   out_eop,   1'b0);
        check("t1_b0_ready", dif.ready, 1'b0);
        check("t1_b0_uuid",  out_uuid,  16'h0011);
        check("t1_b0_pc",    out_PC,    32'h8000_A000);
        check("t1_b0_op",    out_op_type, 4'h5);
        check("t1_b0_args",  out_op_args, 8'h3C);
        check("t1_b0_wis",   out_wis,   2'd2);
        tick();
        check("t1_b1_valid", out_valid, 1'b1);
        check("t1_b1_pid",   out_pid,   1'b1);
        check("t1_b1_rs1",   out_rs1,   {32'hA003, 32'hA002});
        check("t1_b1_sop",   out_sop,   1'b0);
        check("t1_b1_eop",   out_eop,   1'b1);
        check("t1_b1_ready", dif.ready, 1'b1);
        check("t1_b1_uuid",  out_uuid,  16'h0011);
        check("t1_b1_tid",   out_tid,   2'd1);
        check("t1_b1_wb",    out_wb,    1'b1);
        tick();
        check("t1_idle", out_valid, 1'b0);

        // Upper half only: block 0 skipped
        dif.data  = mk(4'b1100, 16'h0022, 32'hB000);
        dif.valid = 1'b1;
        tick();
        dif.valid = 1'b0;
        check("t2_valid", out_valid, 1'b1);
        check("t2_pid",   out_pid,   1'b1);
        check("t2_tmask", out_tmask, 2'b11);
        check("t2_rs1",   out_rs1,   {32'hB003, 32'hB002});
        check("t2_sop",   out_sop,   1'b1);
        check("t2_eop",   out_eop,   1'b1);
        tick();
        check("t2_idle", out_valid, 1'b0);

        // Empty mask: one beat so writeback still flows
        p         = mk(4'b0000, 16'h0033, 32'hC000);
        p.rd      = 6'd9;
        dif.data  = p;
        dif.valid = 1'b1;
        tick();
        dif.valid = 1'b0;
        check("t3_valid", out_valid, 1'b1);
        check("t3_pid",   out_pid,   1'b0);
        check("t3_tmask", out_tmask, 2'b00);
        check("t3_sop",   out_sop,   1'b1);
        check("t3_eop",   out_eop,   1'b1);
        check("t3_wb",    out_wb,    1'b1);
        check("t3_rd",    out_rd,    6'd9);
        tick();
        check("t3_idle", out_valid, 1'b0);

        // Stall on beat 0 for three cycles
        out_ready = 1'b0;
        dif.data  = mk(4'b1111, 16'h0044, 32'hD000);
        dif.valid = 1'b1;
        tick();
        dif.valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t4_stall_valid", out_valid, 1'b1);
            check("t4_stall_pid",   out_pid,   1'b0);
            check("t4_stall_sop",   out_sop,   1'b1);
            check("t4_stall_rs1",   out_rs1,   {32'hD001, 32'hD000});
            check("t4_stall_ready", dif.ready, 1'b0);
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        #1;
        check("t4_release_ready", dif.ready, 1'b0);
        tick();
        check("t4_b1_pid", out_pid, 1'b1);
        check("t4_b1_eop", out_eop, 1'b1);
        check("t4_b1_rs1", out_rs1, {32'hD003, 32'hD002});
        tick();
        check("t4_idle", out_valid, 1'b0);

        // Back-to-back packets: four beats in four consecutive cycles
        dif.data  = mk(4'b1111, 16'h0055, 32'hE000);
        dif.valid = 1'b1;
        tick();
        dif.data  = mk(4'b1111, 16'h0066, 32'hF000);
        check("t5_a0_valid", out_valid, 1'b1);
        check("t5_a0_uuid",  out_uuid,  16'h0055);
        check("t5_a0_ready", dif.ready, 1'b0);
        tick();
        check("t5_a1_valid", out_valid, 1'b1);
        check("t5_a1_pid",   out_pid,   1'b1);
        check("t5_a1_eop",   out_eop,   1'b1);
        check("t5_a1_ready", dif.ready, 1'b1);
        tick();
        dif.valid = 1'b0;
        check("t5_b0_valid", out_valid, 1'b1);
        check("t5_b0_uuid",  out_uuid,  16'h0066);
        check("t5_b0_pid",   out_pid,   1'b0);
        check("t5_b0_sop",   out_sop,   1'b1);
        check("t5_b0_rs1",   out_rs1,   {32'hF001, 32'hF000});
        tick();
        check("t5_b1_valid", out_valid, 1'b1);
        check("t5_b1_pid",   out_pid,   1'b1);
        check("t5_b1_eop",   out_eop,   1'b1);
        check("t5_b1_rs1",   out_rs1,   {32'hF003, 32'hF002});
        tick();
        check("t5_idle", out_valid, 1'b0);

        // Reset mid-packet: remaining beat is dropped
        dif.data  = mk(4'b1111, 16'h0077, 32'h1000);
        dif.valid = 1'b1;
        tick();
        dif.valid = 1'b0;
        check("t6_b0_valid", out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 1'b0);
        check("t6_rst_ready", dif.ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_beat", out_valid, 1'b0);
        end
        check("t6_ready", dif.ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
